// File: rtl/lf_pkg.sv
// Shared fetch-stage definitions: widths, fetch FSM states, NOP encoding and
// the instruction/PC payload carried from fetch to decode.
package lf_pkg;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;

  // LEGv8 NOP encoding
  localparam logic [INSTR_W-1:0] NOP = 32'hD503_201F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  // Instruction word plus the PC it was fetched from
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_pkt_t;

endpackage

// File: rtl/branch_target_calc.sv
// Branch target adder: target = br_pc + (word offset << 2), wrapping at 2^PC_W.
// Ports:
//   br_pc_i     - PC of the resolving branch
//   br_offset_i - sign-extended word offset
//   target_c_o  - combinational branch target
module branch_target_calc
  import lf_pkg::*;
(
  input  logic [PC_W-1:0] br_pc_i,
  input  logic [PC_W-1:0] br_offset_i,
  output logic [PC_W-1:0] target_c_o
);

  // The shift drops the top two offset bits, which is the intended mod-2^64 wrap
  assign target_c_o = br_pc_i + (br_offset_i << 2);

endmodule

// File: rtl/instr_fetch_unit.sv
// LEGv8 fetch stage: owns the PC, issues one outstanding imem request at a
// time, delivers instruction/PC pairs to decode and redirects on taken branches.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   imem_req/imem_addr         - one-cycle fetch request and its address
//   imem_rdata/imem_valid      - instruction memory response
//   br_taken/br_pc/br_offset   - branch redirect from execute
//   stall                      - decode back-pressure
//   if_instr/if_pc/if_valid    - output slot to decode
//   fetch_count                - instructions consumed by decode since reset
module instr_fetch_unit
  import lf_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_pc,
  input  logic [PC_W-1:0]    br_offset,
  input  logic               stall,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               if_valid,
  output logic [31:0]        fetch_count
);

  localparam int unsigned CNT_W = 32;

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              drop_q, drop_d;
  fetch_pkt_t        hold_q, hold_d;
  fetch_pkt_t        out_q, out_d;
  logic              if_valid_q, if_valid_d;
  logic              imem_req_q, imem_req_d;
  logic [PC_W-1:0]   imem_addr_q, imem_addr_d;
  logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

  logic              consume_c;
  logic              can_load_c;
  logic [PC_W-1:0]   target_c;

  branch_target_calc u_btc (
    .br_pc_i     (br_pc),
    .br_offset_i (br_offset),
    .target_c_o  (target_c)
  );

  assign consume_c  = if_valid_q && !stall;
  assign can_load_c = !if_valid_q || !stall;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      drop_q        <= 1'b0;
      hold_q        <= '0;
      out_q         <= '0;
      if_valid_q    <= 1'b0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_q        <= drop_d;
      hold_q        <= hold_d;
      out_q         <= out_d;
      if_valid_q    <= if_valid_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    hold_d        = hold_q;
    out_d         = out_q;
    if_valid_d    = if_valid_q;
    fetch_count_d = fetch_count_q;
    imem_req_d    = 1'b0;
    imem_addr_d   = '0;

    // A consumed slot empties unless something reloads it below
    if (consume_c) begin
      if_valid_d = 1'b0;
    end
    // A slot flushed by a redirect in the same cycle is not counted
    if (consume_c && !br_taken) begin
      fetch_count_d = fetch_count_q + CNT_W'(1);
    end

    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: state_d = WAIT;
      WAIT: begin
        if (imem_valid) begin
          if (drop_q) begin
            // Wrong-path response; pc already points at the target
            drop_d  = 1'b0;
            state_d = FETCH;
          end else if (can_load_c) begin
            out_d      = '{instr: imem_rdata, pc: pc_q};
            if_valid_d = 1'b1;
            pc_d       = pc_q + PC_W'(4);
            state_d    = FETCH;
          end else begin
            hold_d  = '{instr: imem_rdata, pc: pc_q};
            pc_d    = pc_q + PC_W'(4);
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (can_load_c) begin
          out_d      = hold_q;
          if_valid_d = 1'b1;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything above, including back-pressure
    if (br_taken) begin
      pc_d       = target_c;
      out_d      = out_q;
      if_valid_d = 1'b0;
      hold_d     = '0;
      case (state_q)
        FETCH: begin
          drop_d  = 1'b1;
          state_d = WAIT;
        end
        WAIT: begin
          // A response landing with the branch is simply discarded
          drop_d  = !imem_valid;
          state_d = imem_valid ? FETCH : WAIT;
        end
        HOLD: begin
          drop_d  = 1'b0;
          state_d = FETCH;
        end
        default: ;
      endcase
    end

    // Registered request: asserted for the whole cycle spent in FETCH
    imem_req_d  = (state_d == FETCH);
    imem_addr_d = imem_req_d ? pc_d : '0;
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign if_instr    = out_q.instr;
  assign if_pc       = out_q.pc;
  assign if_valid    = if_valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory responder model, delivery
// scoreboard, branch-target vector table and hand-written corner sequences.
module tb_instr_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        br_taken;
  logic [63:0] br_pc;
  logic [63:0] br_offset;
  logic        stall;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        if_valid;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .br_taken    (br_taken),
    .br_pc       (br_pc),
    .br_offset   (br_offset),
    .stall       (stall),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_valid    (if_valid),
    .fetch_count (fetch_count)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [63:0] br_pc;
    logic [63:0] br_off;
    int          delay;     // cycles after a FETCH before br_taken
    logic [63:0] exp_addr;  // first request address after redirect
    int          fill;      // cycles from branch until if_valid returns
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  exp_t        sb_q[$];
  bit          pend = 0;
  bit          pend_killed = 0;
  logic [63:0] pend_addr;
  logic [31:0] pend_data;
  int          pend_cnt = 0;
  int          mem_lat = 1;
  bit          force_en = 0;
  logic [31:0] force_data = 32'hDEAD_BEEF;
  logic [31:0] model_cnt = 32'd0;
  bit          seen_bad = 0;
  int          cyc = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] + 32'h1357_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock: observe the current cycle, advance, then drive memory response
  task automatic tick();
    exp_t e;
    if (imem_req === 1'b1) begin
      pend        = 1;
      pend_killed = 0;
      pend_addr   = imem_addr;
      pend_data   = force_en ? force_data : mem_word(imem_addr);
      pend_cnt    = mem_lat;
    end
    if (if_valid === 1'b1 && if_instr === 32'hDEAD_BEEF) seen_bad = 1;
    if (rst || br_taken) begin
      sb_q.delete();
      pend_killed = 1;
      if (rst) model_cnt = 32'd0;
    end else if (if_valid === 1'b1 && !stall) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual_pc=%h expected=none", if_pc);
      end else begin
        e = sb_q.pop_front();
        check("sb_pc", if_pc, e.pc);
        check("sb_instr", 64'(if_instr), 64'(e.instr));
      end
      model_cnt = model_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_valid = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_valid = 1'b1;
        imem_rdata = pend_data;
        if (!pend_killed) sb_q.push_back('{pc: pend_addr, instr: pend_data});
        pend = 0;
      end
    end
    check("fetch_count", 64'(fetch_count), 64'(model_cnt));
  endtask

  task automatic wait_req(output logic [63:0] a);
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) begin
        a = imem_addr;
        return;
      end
      tick();
    end
    checks++;
    failures++;
    $display("FAIL wait_req actual=timeout expected=imem_req");
    a = '1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 64'(imem_req), 64'd0);
    check({tag, "_addr"}, imem_addr, 64'd0);
    check({tag, "_valid"}, 64'(if_valid), 64'd0);
    check({tag, "_instr"}, 64'(if_instr), 64'd0);
    check({tag, "_pc"}, if_pc, 64'd0);
    check({tag, "_count"}, 64'(fetch_count), 64'd0);
  endtask

  // Align on a FETCH, then stall so the next response parks in HOLD
  task automatic enter_hold();
    logic [63:0] a;
    wait_req(a);
    stall = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    vec_t        vecs[6];
    logic [63:0] a;
    int          b;

    vecs[0] = '{64'h200, 64'hFFFF_FFFF_FFFF_FFFE, 0, 64'h1F8, 4};
    vecs[1] = '{64'h1000, 64'd5, 1, 64'h1014, 3};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'd8, 2, 64'h10, 4};
    vecs[3] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 3, 64'hFFFF_FFFF_FFFF_FFFC, 3};
    vecs[4] = '{64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 0, 64'h4000_0000_0000_0000, 4};
    vecs[5] = '{64'h0123_4567_89AB_CDEF, 64'h10, 1, 64'h0123_4567_89AB_CE2F, 3};

    rst = 1'b1; imem_rdata = '0; imem_valid = 1'b0; br_taken = 1'b0;
    br_pc = '0; br_offset = '0; stall = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // Sequential fetch from RESET_PC
    wait_req(a); check("start_addr0", a, 64'h100);
    tick();
    wait_req(a); check("start_addr1", a, 64'h104);
    tick();
    wait_req(a); check("start_addr2", a, 64'h108);
    for (int i = 0; i < 30 && model_cnt < 32'd3; i++) tick();
    check("count_after_3", 64'(fetch_count), 64'd3);

    // Back-pressure: response parks in HOLD, no new requests, slot stable
    enter_hold();
    for (int i = 0; i < 5; i++) begin
      check("hold_no_req", 64'(imem_req), 64'd0);
      check("hold_valid", 64'(if_valid), 64'd1);
      if (sb_q.size() > 0) check("hold_instr", 64'(if_instr), 64'(sb_q[0].instr));
      tick();
    end
    stall = 1'b0;
    repeat (6) tick();

    // Redirect vectors across FETCH / WAIT(+response) states
    foreach (vecs[i]) begin
      wait_req(a);
      repeat (vecs[i].delay) tick();
      br_taken = 1'b1; br_pc = vecs[i].br_pc; br_offset = vecs[i].br_off;
      b = cyc;
      tick();
      br_taken = 1'b0;
      check("br_flush_valid", 64'(if_valid), 64'd0);
      wait_req(a);
      check("br_target", a, vecs[i].exp_addr);
      while (cyc < b + vecs[i].fill - 1) tick();
      check("br_refill_early", 64'(if_valid), 64'd0);
      tick();
      check("br_refill", 64'(if_valid), 64'd1);
      repeat (3) tick();
    end

    // Redirect while HOLDing under stall: flush wins
    enter_hold();
    br_taken = 1'b1; br_pc = 64'h3000; br_offset = 64'd4;
    tick();
    br_taken = 1'b0;
    check("hold_br_valid", 64'(if_valid), 64'd0);
    wait_req(a);
    check("hold_br_target", a, 64'h3010);
    repeat (3) tick();
    stall = 1'b0;
    repeat (4) tick();

    // Redirect in WAIT with a slow stale response
    wait_req(a);
    force_en = 1; mem_lat = 3;
    tick();
    force_en = 0;
    br_taken = 1'b1; br_pc = 64'h4FF0; br_offset = 64'd4;
    tick();
    br_taken = 1'b0;
    mem_lat = 1;
    wait_req(a);
    check("stale_target", a, 64'h5000);
    repeat (6) tick();

    // PC wrap at 2^64
    wait_req(a);
    br_taken = 1'b1; br_pc = 64'hFFFF_FFFF_FFFF_FFF8; br_offset = 64'd1;
    tick();
    br_taken = 1'b0;
    wait_req(a); check("wrap_top", a, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    wait_req(a); check("wrap_zero", a, 64'h0);
    repeat (4) tick();

    // Reset mid-WAIT, stale response arrives after reset
    mem_lat = 3;
    wait_req(a);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midrst");
    tick();
    wait_req(a);
    check("midrst_addr", a, RST_PC);
    repeat (6) tick();
    check("midrst_count", 64'(fetch_count), 64'd1);
    repeat (4) tick();

    check("no_stale_word", 64'(seen_bad), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
